// File: rtl/vmem_fill.sv
// vmem_fill: memory-mapped rectangle-fill engine feeding the video memory
// write port. The CPU programs origin, size and colour, then starts the
// engine. It streams one clipped 3-bit pixel per accepted cycle in {y,x}
// address order, with x as the inner loop.
module vmem_fill #(
    parameter int LCD_W = 240,  // panel width in pixels (max 256)
    parameter int LCD_H = 240   // panel height in pixels (max 256)
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        wen_i,
    input  logic [3:0]  addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        vm_we_o,
    output logic [15:0] vm_waddr_o,
    output logic [2:0]  vm_wdata_o,
    input  logic        vm_ready_i,
    output logic        busy_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        RUN   = 2'd2
    } state_t;

    localparam logic [8:0] LCD_W9 = 9'(LCD_W);
    localparam logic [8:0] LCD_H9 = 9'(LCD_H);

    state_t state, next_state;

    // Programmed configuration
    logic [7:0] x0, y0, w, h;
    logic [2:0] color;

    // Status
    logic [15:0] pix_cnt;
    logic        done, aborted;

    // Scan position and clipped inclusive end coordinates
    logic [7:0] cx, cy;
    logic [8:0] xe, ye;

    // Decoded register accesses
    logic ctrl_wr, cfg_wr, start_req, abort_req, clr_req;

    // FSM decisions consumed by the datapath
    logic start_go, abort_go, setup_empty, setup_load, run_last;

    // Setup arithmetic (9-bit so x0+w cannot wrap)
    logic [8:0] x_sum, y_sum, x_lim, y_lim, xe_calc, ye_calc;
    logic       rect_empty;

    // Scan helpers
    logic accept, row_end, at_last;

    logic [31:0] rd_mux;

    // Bits of the bus that no register uses
    logic unused_bits;
    assign unused_bits = ^{addr_i[1:0], wdata_i[31:16]};

    assign ctrl_wr   = wen_i && (addr_i[3:2] == 2'd0);
    assign cfg_wr    = wen_i && (state == IDLE);
    assign start_req = ctrl_wr && wdata_i[0];
    assign abort_req = ctrl_wr && wdata_i[1];
    assign clr_req   = ctrl_wr && wdata_i[2];

    assign x_sum   = {1'b0, x0} + {1'b0, w};
    assign y_sum   = {1'b0, y0} + {1'b0, h};
    assign x_lim   = (x_sum > LCD_W9) ? LCD_W9 : x_sum;
    assign y_lim   = (y_sum > LCD_H9) ? LCD_H9 : y_sum;
    assign xe_calc = x_lim - 9'd1;
    assign ye_calc = y_lim - 9'd1;

    assign rect_empty = (w == 8'd0) || (h == 8'd0) ||
                        ({1'b0, x0} >= LCD_W9) || ({1'b0, y0} >= LCD_H9);

    assign accept  = vm_we_o && vm_ready_i;
    assign row_end = ({1'b0, cx} == xe);
    assign at_last = row_end && ({1'b0, cy} == ye);

    assign busy_o     = (state != IDLE);
    assign vm_waddr_o = {cy, cx};

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: clocked state is always assigned with <= so every flop samples
        // the pre-edge values of the others, independent of block ordering.
        if (!rst_ni) state <= IDLE;
        else         state <= next_state;
    end

    // Next-state logic and the one-cycle decisions that drive the datapath
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a value
        // unassigned, which would otherwise infer a latch.
        next_state  = state;
        start_go    = 1'b0;
        abort_go    = 1'b0;
        setup_empty = 1'b0;
        setup_load  = 1'b0;
        run_last    = 1'b0;
        case (state)
            IDLE: begin
                // ABORT in the same write cancels START outright
                if (start_req && !abort_req) begin
                    next_state = SETUP;
                    start_go   = 1'b1;
                end
            end
            SETUP: begin
                if (abort_req) begin
                    next_state = IDLE;
                    abort_go   = 1'b1;
                end else if (rect_empty) begin
                    next_state  = IDLE;
                    setup_empty = 1'b1;
                end else begin
                    next_state = RUN;
                    setup_load = 1'b1;
                end
            end
            RUN: begin
                if (abort_req) begin
                    next_state = IDLE;
                    abort_go   = 1'b1;
                end else if (accept && at_last) begin
                    next_state = IDLE;
                    run_last   = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Configuration registers, writable only while idle
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            x0    <= '0;
            y0    <= '0;
            w     <= '0;
            h     <= '0;
            color <= '0;
        end else if (cfg_wr) begin
            case (addr_i[3:2])
                2'd1: begin
                    x0 <= wdata_i[7:0];
                    y0 <= wdata_i[15:8];
                end
                2'd2: begin
                    w <= wdata_i[7:0];
                    h <= wdata_i[15:8];
                end
                2'd3: color <= wdata_i[2:0];
                default: ;
            endcase
        end
    end

    // Pixel counter and sticky completion flags; completion beats CLR_DONE
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pix_cnt <= '0;
            done    <= 1'b0;
            aborted <= 1'b0;
        end else if (start_go) begin
            pix_cnt <= '0;
            done    <= 1'b0;
            aborted <= 1'b0;
        end else begin
            // A write accepted in the same cycle as ABORT still counts
            if (accept) pix_cnt <= pix_cnt + 16'd1;

            if (abort_go || setup_empty || run_last) done <= 1'b1;
            else if (clr_req)                        done <= 1'b0;

            if (abort_go)     aborted <= 1'b1;
            else if (clr_req) aborted <= 1'b0;
        end
    end

    // Scan walker: latches clip bounds in SETUP, holds address while stalled
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cx         <= '0;
            cy         <= '0;
            xe         <= '0;
            ye         <= '0;
            vm_we_o    <= 1'b0;
            vm_wdata_o <= '0;
        end else begin
            if (state == SETUP) begin
                xe <= xe_calc;
                ye <= ye_calc;
            end

            if (setup_load) begin
                cx         <= x0;
                cy         <= y0;
                vm_we_o    <= 1'b1;
                vm_wdata_o <= color;
            end else if (abort_go || run_last) begin
                vm_we_o <= 1'b0;
            end else if (accept) begin
                if (row_end) begin
                    cx <= x0;
                    cy <= cy + 8'd1;
                end else begin
                    cx <= cx + 8'd1;
                end
            end
        end
    end

    // Read-data mux, registered below for one-cycle read latency
    always_comb begin
        rd_mux = '0;
        case (addr_i[3:2])
            2'd0: rd_mux = {pix_cnt, 13'b0, aborted, done, busy_o};
            2'd1: rd_mux = {16'b0, y0, x0};
            2'd2: rd_mux = {16'b0, h, w};
            2'd3: rd_mux = {29'b0, color};
            default: rd_mux = '0;
        endcase
    end

    // Registered read data
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) rdata_o <= '0;
        else         rdata_o <= rd_mux;
    end

endmodule

// File: tb/tb_vmem_fill.sv
// tb_vmem_fill: table-driven fills checked against a scoreboard of expected
// vmem writes, plus hand-written stall, abort and reset sequences.
module tb_vmem_fill;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        wen_i;
    logic [3:0]  addr_i;
    logic [31:0] wdata_i;
    logic [31:0] rdata_o;
    logic        vm_we_o;
    logic [15:0] vm_waddr_o;
    logic [2:0]  vm_wdata_o;
    logic        vm_ready_i;
    logic        busy_o;

    vmem_fill #(.LCD_W(240), .LCD_H(240)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .wen_i      (wen_i),
        .addr_i     (addr_i),
        .wdata_i    (wdata_i),
        .rdata_o    (rdata_o),
        .vm_we_o    (vm_we_o),
        .vm_waddr_o (vm_waddr_o),
        .vm_wdata_o (vm_wdata_o),
        .vm_ready_i (vm_ready_i),
        .busy_o     (busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [15:0] addr;
        logic [2:0]  data;
    } wr_t;

    typedef struct {
        logic [7:0]  x0;
        logic [7:0]  y0;
        logic [7:0]  w;
        logic [7:0]  h;
        logic [2:0]  color;
        logic [15:0] cnt;   // expected pixel count after the fill
    } fill_vec_t;

    wr_t       exp_q[$];
    fill_vec_t vecs[8];
    int        n_vec  = 0;
    int        n_miss = 0;
    int        acc_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every write accepted at the next rising edge must match the queue head
    always @(negedge clk_i) begin
        if (rst_ni && vm_we_o && vm_ready_i) begin
            acc_cnt++;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected_write: got addr %h data %h, none pending", vm_waddr_o, vm_wdata_o);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", 32'(vm_waddr_o), 32'(e.addr));
                check("wr_data", 32'(vm_wdata_o), 32'(e.data));
            end
        end
    end

    task automatic reg_wr(input logic [3:0] a, input logic [31:0] d);
        @(posedge clk_i); #1;
        wen_i = 1'b1; addr_i = a; wdata_i = d;
        @(posedge clk_i); #1;
        wen_i = 1'b0;
    endtask

    task automatic reg_rd(input logic [3:0] a, output logic [31:0] d);
        @(posedge clk_i); #1;
        addr_i = a;
        @(posedge clk_i); #1;
        d = rdata_o;
    endtask

    // Returns just after the edge that samples the START write
    task automatic do_start();
        @(posedge clk_i); #1;
        wen_i = 1'b1; addr_i = 4'h0; wdata_i = 32'h1;
        @(posedge clk_i); #1;
        wen_i = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy_o && n < budget) begin
            @(posedge clk_i); #1;
            n++;
        end
        check("idle_timeout", 32'(busy_o), 32'd0);
    endtask

    task automatic push_rect(input fill_vec_t v);
        for (int yy = int'(v.y0); yy < int'(v.y0) + int'(v.h); yy++)
            for (int xx = int'(v.x0); xx < int'(v.x0) + int'(v.w); xx++)
                if (xx < 240 && yy < 240)
                    exp_q.push_back('{addr: {yy[7:0], xx[7:0]}, data: v.color});
    endtask

    task automatic run_fill(input fill_vec_t v);
        logic [31:0] d;
        reg_wr(4'h4, {16'h0, v.y0, v.x0});
        reg_wr(4'h8, {16'h0, v.h, v.w});
        reg_wr(4'hC, {29'h0, v.color});
        reg_rd(4'h4, d); check("origin_rb", d, {16'h0, v.y0, v.x0});
        reg_rd(4'h8, d); check("size_rb",   d, {16'h0, v.h, v.w});
        reg_rd(4'hC, d); check("color_rb",  d, {29'h0, v.color});
        push_rect(v);
        do_start();
        check("busy_t1", 32'(busy_o), 32'd1);
        check("we_t1",   32'(vm_we_o), 32'd0);
        @(posedge clk_i); #1;
        if (v.cnt != 16'd0) begin
            check("we_t2", 32'(vm_we_o), 32'd1);
        end else begin
            check("empty_busy_t2", 32'(busy_o), 32'd0);
            check("empty_we_t2",   32'(vm_we_o), 32'd0);
        end
        wait_idle(400);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        reg_rd(4'h0, d);
        check("status", d, {v.cnt, 16'h0002});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int n;

        vecs[0] = '{8'h0A, 8'h14, 8'd2, 8'd2, 3'd5, 16'd4};   // basic 2x2
        vecs[1] = '{8'd238, 8'd239, 8'd5, 8'd3, 3'd3, 16'd2}; // clipped both axes
        vecs[2] = '{8'd5, 8'd5, 8'd0, 8'd4, 3'd1, 16'd0};     // w = 0
        vecs[3] = '{8'd240, 8'd0, 8'd4, 8'd4, 3'd2, 16'd0};   // x0 off panel
        vecs[4] = '{8'd0, 8'd0, 8'd3, 8'd0, 3'd7, 16'd0};     // h = 0
        vecs[5] = '{8'd239, 8'd239, 8'd1, 8'd1, 3'd6, 16'd1}; // last pixel only
        vecs[6] = '{8'd100, 8'd50, 8'd3, 8'd2, 3'd4, 16'd6};  // 3x2 interior
        vecs[7] = '{8'd0, 8'd238, 8'd2, 8'd10, 3'd1, 16'd4};  // clipped in y

        rst_ni = 1'b0; wen_i = 1'b0; addr_i = '0; wdata_i = '0; vm_ready_i = 1'b1;
        #12;
        check("rst_we",    32'(vm_we_o), 32'd0);
        check("rst_busy",  32'(busy_o), 32'd0);
        check("rst_waddr", 32'(vm_waddr_o), 32'd0);
        check("rst_wdata", 32'(vm_wdata_o), 32'd0);
        check("rst_rdata", rdata_o, 32'd0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;

        for (int i = 0; i < 8; i++) run_fill(vecs[i]);

        // Stall: 4x1 fill, ready low for 3 cycles while the second pixel is shown
        reg_wr(4'h4, 32'h0000_2010);
        reg_wr(4'h8, 32'h0000_0104);
        reg_wr(4'hC, 32'h0000_0002);
        push_rect('{8'h10, 8'h20, 8'd4, 8'd1, 3'd2, 16'd4});
        acc_cnt = 0;
        do_start();
        @(posedge clk_i); #1;
        check("stall_first", 32'(vm_waddr_o), 32'h2010);
        @(posedge clk_i); #1;
        vm_ready_i = 1'b0;
        check("stall_second", 32'(vm_waddr_o), 32'h2011);
        repeat (3) begin
            @(posedge clk_i); #1;
            check("stall_hold_addr", 32'(vm_waddr_o), 32'h2011);
            check("stall_hold_we",   32'(vm_we_o), 32'd1);
        end
        vm_ready_i = 1'b1;
        wait_idle(100);
        check("stall_accepts", 32'(acc_cnt), 32'd4);
        check("stall_drained", 32'(exp_q.size()), 32'd0);
        reg_rd(4'h0, d);
        check("stall_status", d, 32'h0004_0002);

        // Abort a full-screen fill after 100 accepted writes
        reg_wr(4'h4, 32'h0000_0000);
        reg_wr(4'h8, 32'h0000_F0F0);
        reg_wr(4'hC, 32'h0000_0007);
        for (int xx = 0; xx < 100; xx++) exp_q.push_back('{addr: {8'h00, xx[7:0]}, data: 3'd7});
        acc_cnt = 0;
        do_start();
        n = 0;
        while (acc_cnt < 100 && n < 1000) begin
            @(posedge clk_i); #1;
            n++;
        end
        check("abort_wait", 32'(acc_cnt), 32'd100);
        vm_ready_i = 1'b0;
        wen_i = 1'b1; addr_i = 4'h0; wdata_i = 32'h2;
        @(posedge clk_i); #1;
        wen_i = 1'b0;
        check("abort_we",   32'(vm_we_o), 32'd0);
        check("abort_busy", 32'(busy_o), 32'd0);
        vm_ready_i = 1'b1;
        reg_rd(4'h0, d);
        check("abort_status", d, 32'h0064_0006);
        check("abort_drained", 32'(exp_q.size()), 32'd0);

        // CLR_DONE clears both flags; START+ABORT while idle changes nothing
        reg_wr(4'h0, 32'h4);
        reg_rd(4'h0, d);
        check("clr_status", d, 32'h0064_0000);
        reg_wr(4'h0, 32'h3);
        check("start_abort_busy", 32'(busy_o), 32'd0);
        reg_rd(4'h0, d);
        check("start_abort_status", d, 32'h0064_0000);

        // Asynchronous reset in the middle of a run
        reg_wr(4'h4, 32'h0000_0000);
        reg_wr(4'h8, 32'h0000_0A0A);
        reg_wr(4'hC, 32'h0000_0003);
        push_rect('{8'd0, 8'd0, 8'd10, 8'd10, 3'd3, 16'd100});
        do_start();
        repeat (8) @(posedge clk_i);
        #3;
        rst_ni = 1'b0;
        #1;
        check("arst_we",   32'(vm_we_o), 32'd0);
        check("arst_busy", 32'(busy_o), 32'd0);
        exp_q.delete();
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        reg_rd(4'h0, d);
        check("arst_status", d, 32'h0);
        reg_rd(4'h4, d);
        check("arst_origin", d, 32'h0);
        run_fill(vecs[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
